// File: rtl/vc_credit_link_arb.sv
// vc_credit_link_arb: output-link scheduler. Shares one physical link among
// VC_W virtual channels with round-robin arbitration, tracks downstream buffer
// space with per-VC credit counters, and drives a registered payload plus a
// one-hot VC valid.
module vc_credit_link_arb #(
    parameter int N       = 4,
    parameter int A_W     = 3,
    parameter int D_W     = 32,
    parameter int VC_W    = 2,
    parameter int CREDITS = 4,
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [VC_W-1:0][A_W+D_W:0] i,
    input  logic [VC_W-1:0]            i_v,
    output logic [VC_W-1:0]            i_bp,
    output logic [A_W+D_W:0]           o,
    output logic [VC_W-1:0]            o_v,
    input  logic [VC_W-1:0]            credit_ret,
    output logic [VC_W-1:0]            credit_avail,
    output logic                       cred_ovf
);

    localparam int P_W   = A_W + D_W + 1;
    localparam int PTR_W = (VC_W > 1) ? $clog2(VC_W) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);

    // N is carried only so the block matches its neighbours' parameter set.
    if (N < 1 || VC_W < 1 || CREDITS < 1) begin : g_param_check
        $error("vc_credit_link_arb: N, VC_W and CREDITS must all be at least 1");
    end

    logic [VC_W-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic [P_W-1:0]             o_q, o_d;
    logic [VC_W-1:0]            o_v_q, o_v_d;
    logic                       cred_ovf_q, cred_ovf_d;

    logic [VC_W-1:0]            elig;
    logic [VC_W-1:0]            gnt;
    logic [PTR_W-1:0]           gnt_idx;
    logic                       gnt_any;

    // Credit availability from registered counts only, so a returned credit
    // becomes usable one cycle later and credit_ret never reaches i_bp or o.
    always_comb begin
        credit_avail = '0;
        for (int v = 0; v < VC_W; v++) begin
            credit_avail[v] = (cnt_q[v] != '0);
        end
        elig = rst ? '0 : (i_v & credit_avail);
    end

    // Round-robin pick: first eligible VC scanning from ptr upward with wrap.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < VC_W; k++) begin
            if (!gnt_any && elig[(int'(ptr_q) + k) % VC_W]) begin
                gnt[(int'(ptr_q) + k) % VC_W] = 1'b1;
                gnt_idx = PTR_W'((int'(ptr_q) + k) % VC_W);
                gnt_any = 1'b1;
            end
        end
    end

    // Output register and pointer next-state: payload holds when idle.
    always_comb begin
        o_d   = o_q;
        o_v_d = gnt;
        ptr_d = ptr_q;
        if (gnt_any) begin
            o_d = i[gnt_idx];
            if (int'(gnt_idx) == VC_W - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + PTR_W'(1);
            end
        end
    end

    // Credit counters: grant consumes, return refills; a return into a full
    // counter is dropped and latches the sticky overflow flag.
    always_comb begin
        cnt_d      = cnt_q;
        cred_ovf_d = cred_ovf_q;
        for (int v = 0; v < VC_W; v++) begin
            case ({gnt[v], credit_ret[v]})
                2'b10: cnt_d[v] = cnt_q[v] - CNT_W'(1);
                2'b01: begin
                    if (cnt_q[v] == CNT_FULL) begin
                        cred_ovf_d = 1'b1;
                    end else begin
                        cnt_d[v] = cnt_q[v] + CNT_W'(1);
                    end
                end
                default: cnt_d[v] = cnt_q[v];
            endcase
        end
    end

    // State registers with synchronous reset; downstream buffers share rst,
    // so restoring full credit keeps both sides consistent.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= {VC_W{CNT_FULL}};
            ptr_q      <= '0;
            o_q        <= '0;
            o_v_q      <= '0;
            cred_ovf_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            o_q        <= o_d;
            o_v_q      <= o_v_d;
            cred_ovf_q <= cred_ovf_d;
        end
    end

    // Port drives.
    always_comb begin
        i_bp     = i_v & ~gnt;
        o        = o_q;
        o_v      = o_v_q;
        cred_ovf = cred_ovf_q;
    end

endmodule

// File: tb/tb_vc_credit_link_arb.sv
// Testbench for vc_credit_link_arb with VC_W=2, CREDITS=4, 36-bit payload.
module tb_vc_credit_link_arb;

    localparam int VC_W    = 2;
    localparam int A_W     = 3;
    localparam int D_W     = 32;
    localparam int CREDITS = 4;
    localparam int P_W     = A_W + D_W + 1;

    localparam logic [P_W-1:0] PA = 36'h0_ABCDABCD;
    localparam logic [P_W-1:0] PB = 36'h5_12345678;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [VC_W-1:0][P_W-1:0]  i_in;
    logic [VC_W-1:0]           i_v;
    logic [VC_W-1:0]           i_bp;
    logic [P_W-1:0]            o;
    logic [VC_W-1:0]           o_v;
    logic [VC_W-1:0]           credit_ret;
    logic [VC_W-1:0]           credit_avail;
    logic                      cred_ovf;

    int checks = 0;
    int errors = 0;

    vc_credit_link_arb #(
        .N(4), .A_W(A_W), .D_W(D_W), .VC_W(VC_W), .CREDITS(CREDITS)
    ) dut (
        .clk(clk), .rst(rst), .i(i_in), .i_v(i_v), .i_bp(i_bp), .o(o), .o_v(o_v),
        .credit_ret(credit_ret), .credit_avail(credit_avail), .cred_ovf(cred_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            r;
        logic [1:0]      iv;
        logic [1:0]      ret;
        logic [P_W-1:0]  p0;
        logic [P_W-1:0]  p1;
        logic [1:0]      bp;
        logic [1:0]      ov;
        logic [1:0]      av;
        logic            ovf;
        logic [P_W-1:0]  eo;
    } vec_t;

    function automatic vec_t mk(logic r, logic [1:0] iv, logic [1:0] ret,
                                logic [P_W-1:0] p0, logic [P_W-1:0] p1,
                                logic [1:0] bp, logic [1:0] ov, logic [1:0] av,
                                logic ovf, logic [P_W-1:0] eo);
        vec_t t;
        t.r = r; t.iv = iv; t.ret = ret; t.p0 = p0; t.p1 = p1;
        t.bp = bp; t.ov = ov; t.av = av; t.ovf = ovf; t.eo = eo;
        return t;
    endfunction

    task automatic chk(input string name, input logic [P_W-1:0] act, input logic [P_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; lb loops o_v back as credit_ret.
    task automatic apply(input logic r, input logic [1:0] iv, input logic [1:0] ret,
                         input logic [P_W-1:0] p0, input logic [P_W-1:0] p1, input bit lb);
        @(negedge clk);
        rst        = r;
        i_v        = iv;
        credit_ret = lb ? o_v : ret;
        i_in[0]    = p0;
        i_in[1]    = p1;
        #1;
    endtask

    vec_t tbl[$];

    // reference model state
    int             m_cnt[VC_W];
    int             m_ptr;
    logic [P_W-1:0] m_o;
    logic [1:0]     m_ov;
    logic           m_ovf;

    initial begin
        logic [1:0]     iv, ret, bp_prev, iv_prev, ebp, gmask, av;
        logic [P_W-1:0] pay[VC_W];
        logic           r;
        int             g;

        rst = 1'b1; i_v = '0; credit_ret = '0; i_in = '0;

        // credit exhaustion on VC0, then overflow on VC1
        tbl.push_back(mk(1, 2'b01, 2'b00, PA, 0,  2'b01, 2'b00, 2'b11, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, PA, 0,  2'b00, 2'b00, 2'b11, 0, 0));
        tbl.push_back(mk(0, 2'b01, 2'b00, PA, 0,  2'b00, 2'b01, 2'b11, 0, PA));
        tbl.push_back(mk(0, 2'b01, 2'b00, PA, 0,  2'b00, 2'b01, 2'b11, 0, PA));
        tbl.push_back(mk(0, 2'b01, 2'b00, PA, 0,  2'b00, 2'b01, 2'b11, 0, PA));
        tbl.push_back(mk(0, 2'b01, 2'b00, PA, 0,  2'b01, 2'b01, 2'b10, 0, PA));
        tbl.push_back(mk(0, 2'b01, 2'b01, PA, 0,  2'b01, 2'b00, 2'b10, 0, PA));
        tbl.push_back(mk(0, 2'b01, 2'b00, PA, 0,  2'b00, 2'b00, 2'b11, 0, PA));
        tbl.push_back(mk(0, 2'b01, 2'b00, PA, 0,  2'b01, 2'b01, 2'b10, 0, PA));
        tbl.push_back(mk(0, 2'b00, 2'b00, PA, 0,  2'b00, 2'b00, 2'b10, 0, PA));
        tbl.push_back(mk(1, 2'b00, 2'b00, PA, 0,  2'b00, 2'b00, 2'b10, 0, PA));
        tbl.push_back(mk(0, 2'b00, 2'b10, PA, 0,  2'b00, 2'b00, 2'b11, 0, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, PA, 0,  2'b00, 2'b00, 2'b11, 1, 0));
        tbl.push_back(mk(0, 2'b10, 2'b00, PA, PB, 2'b00, 2'b00, 2'b11, 1, 0));
        tbl.push_back(mk(0, 2'b00, 2'b10, PA, PB, 2'b00, 2'b10, 2'b11, 1, PB));
        tbl.push_back(mk(0, 2'b00, 2'b10, PA, PB, 2'b00, 2'b00, 2'b11, 1, PB));
        tbl.push_back(mk(0, 2'b00, 2'b00, PA, PB, 2'b00, 2'b00, 2'b11, 1, PB));
        // VC1 must still hold exactly 4 credits after the dropped return
        tbl.push_back(mk(0, 2'b10, 2'b00, PA, PB, 2'b00, 2'b00, 2'b11, 1, PB));
        tbl.push_back(mk(0, 2'b10, 2'b00, PA, PB, 2'b00, 2'b10, 2'b11, 1, PB));
        tbl.push_back(mk(0, 2'b10, 2'b00, PA, PB, 2'b00, 2'b10, 2'b11, 1, PB));
        tbl.push_back(mk(0, 2'b10, 2'b00, PA, PB, 2'b00, 2'b10, 2'b11, 1, PB));
        tbl.push_back(mk(0, 2'b10, 2'b00, PA, PB, 2'b10, 2'b10, 2'b01, 1, PB));
        tbl.push_back(mk(0, 2'b00, 2'b00, PA, PB, 2'b00, 2'b00, 2'b01, 1, PB));
        tbl.push_back(mk(0, 2'b00, 2'b10, PA, PB, 2'b00, 2'b00, 2'b01, 1, PB));
        tbl.push_back(mk(0, 2'b00, 2'b10, PA, PB, 2'b00, 2'b00, 2'b11, 1, PB));

        foreach (tbl[n]) begin
            apply(tbl[n].r, tbl[n].iv, tbl[n].ret, tbl[n].p0, tbl[n].p1, 0);
            chk($sformatf("tbl%0d i_bp", n), P_W'(i_bp), P_W'(tbl[n].bp));
            chk($sformatf("tbl%0d o_v", n), P_W'(o_v), P_W'(tbl[n].ov));
            chk($sformatf("tbl%0d credit_avail", n), P_W'(credit_avail), P_W'(tbl[n].av));
            chk($sformatf("tbl%0d cred_ovf", n), P_W'(cred_ovf), P_W'(tbl[n].ovf));
            chk($sformatf("tbl%0d o", n), o, tbl[n].eo);
        end

        // round robin with credit loopback, starting from ptr=0
        for (int k = 0; k < 8; k++) begin
            apply(0, 2'b11, 2'b00, PA, PB, 1);
            chk($sformatf("rr%0d i_bp", k), P_W'(i_bp), (k % 2 == 0) ? P_W'(2'b10) : P_W'(2'b01));
            if (k == 0) chk("rr0 o_v", P_W'(o_v), P_W'(2'b00));
            else begin
                chk($sformatf("rr%0d o_v", k), P_W'(o_v), (k % 2 == 1) ? P_W'(2'b01) : P_W'(2'b10));
                chk($sformatf("rr%0d o", k), o, (k % 2 == 1) ? PA : PB);
            end
        end

        // reset in the middle of the round-robin stream
        apply(1, 2'b11, 2'b00, PA, PB, 1);
        chk("mid_rst i_bp", P_W'(i_bp), P_W'(2'b11));
        chk("mid_rst o_v_before", P_W'(o_v), P_W'(2'b10));
        chk("mid_rst ovf_before", P_W'(cred_ovf), P_W'(1'b1));
        apply(0, 2'b11, 2'b00, PA, PB, 1);
        chk("post_rst o_v", P_W'(o_v), P_W'(2'b00));
        chk("post_rst cred_ovf", P_W'(cred_ovf), P_W'(1'b0));
        chk("post_rst credit_avail", P_W'(credit_avail), P_W'(2'b11));
        chk("post_rst i_bp", P_W'(i_bp), P_W'(2'b10));
        apply(0, 2'b11, 2'b00, PA, PB, 1);
        chk("post_rst first o_v", P_W'(o_v), P_W'(2'b01));
        chk("post_rst first o", o, PA);

        // work conservation: VC1 drained, VC0 keeps flowing
        apply(1, 2'b00, 2'b00, PA, PB, 0);
        for (int k = 0; k < 4; k++) begin
            apply(0, 2'b10, 2'b00, PA, PB, 0);
            chk($sformatf("drain%0d i_bp", k), P_W'(i_bp), P_W'(2'b00));
        end
        for (int k = 0; k < 6; k++) begin
            apply(0, 2'b11, 2'b01, PA, PB, 0);
            chk($sformatf("wc%0d i_bp", k), P_W'(i_bp), P_W'(2'b10));
            chk($sformatf("wc%0d credit_avail", k), P_W'(credit_avail), P_W'(2'b01));
            chk($sformatf("wc%0d o_v", k), P_W'(o_v), (k == 0) ? P_W'(2'b10) : P_W'(2'b01));
        end
        chk("wc cred_ovf", P_W'(cred_ovf), P_W'(1'b0));

        // grant and return on the same VC at cnt=1
        apply(1, 2'b00, 2'b00, PA, PB, 0);
        for (int k = 0; k < 3; k++) apply(0, 2'b01, 2'b00, PA, PB, 0);
        apply(0, 2'b01, 2'b01, PA, PB, 0);
        chk("same_cyc i_bp", P_W'(i_bp), P_W'(2'b00));
        chk("same_cyc credit_avail", P_W'(credit_avail), P_W'(2'b11));
        apply(0, 2'b01, 2'b00, PA, PB, 0);
        chk("same_cyc next i_bp", P_W'(i_bp), P_W'(2'b00));
        chk("same_cyc next o_v", P_W'(o_v), P_W'(2'b01));
        apply(0, 2'b01, 2'b00, PA, PB, 0);
        chk("same_cyc empty i_bp", P_W'(i_bp), P_W'(2'b01));
        chk("same_cyc empty avail", P_W'(credit_avail), P_W'(2'b10));
        chk("same_cyc empty o_v", P_W'(o_v), P_W'(2'b01));
        chk("same_cyc ovf", P_W'(cred_ovf), P_W'(1'b0));

        // randomized traffic against the reference model
        apply(1, 2'b00, 2'b00, 0, 0, 0);
        for (int v = 0; v < VC_W; v++) begin
            m_cnt[v] = CREDITS;
            pay[v]   = '0;
        end
        m_ptr = 0; m_o = '0; m_ov = '0; m_ovf = 1'b0;
        bp_prev = '0; iv_prev = '0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 99) == 0);
            for (int v = 0; v < VC_W; v++) begin
                if (iv_prev[v] && bp_prev[v]) begin
                    iv[v] = 1'b1;
                end else begin
                    iv[v]  = ($urandom_range(0, 3) != 0);
                    pay[v] = P_W'({$urandom(), $urandom()});
                end
                if (m_cnt[v] < CREDITS) ret[v] = ($urandom_range(0, 99) < 40);
                else                    ret[v] = ($urandom_range(0, 99) < 3);
            end
            apply(r, iv, ret, pay[0], pay[1], 0);

            g = -1;
            if (!r) begin
                for (int off = 0; off < VC_W; off++) begin
                    if (g < 0 && iv[(m_ptr + off) % VC_W] && m_cnt[(m_ptr + off) % VC_W] > 0)
                        g = (m_ptr + off) % VC_W;
                end
            end
            gmask = (g >= 0) ? 2'(1 << g) : 2'b00;
            ebp   = iv & ~gmask;
            for (int v = 0; v < VC_W; v++) av[v] = (m_cnt[v] > 0);

            chk($sformatf("rnd%0d i_bp", n), P_W'(i_bp), P_W'(ebp));
            chk($sformatf("rnd%0d o_v", n), P_W'(o_v), P_W'(m_ov));
            chk($sformatf("rnd%0d o", n), o, m_o);
            chk($sformatf("rnd%0d credit_avail", n), P_W'(credit_avail), P_W'(av));
            chk($sformatf("rnd%0d cred_ovf", n), P_W'(cred_ovf), P_W'(m_ovf));

            if (r) begin
                for (int v = 0; v < VC_W; v++) m_cnt[v] = CREDITS;
                m_ptr = 0; m_o = '0; m_ov = '0; m_ovf = 1'b0;
            end else begin
                if (g >= 0) begin
                    m_o   = pay[g];
                    m_ov  = gmask;
                    m_ptr = (g + 1) % VC_W;
                end else begin
                    m_ov = '0;
                end
                for (int v = 0; v < VC_W; v++) begin
                    if (ret[v] && !gmask[v]) begin
                        if (m_cnt[v] == CREDITS) m_ovf = 1'b1;
                        else                     m_cnt[v] = m_cnt[v] + 1;
                    end else if (gmask[v] && !ret[v]) begin
                        m_cnt[v] = m_cnt[v] - 1;
                    end
                end
            end
            bp_prev = ebp;
            iv_prev = iv;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vc_credit_link_arb.md
Name: vc_credit_link_arb

Overview:
- Output-link scheduler placed between a t_switch output direction and the physical inter-switch link.
- Shares one link among VC_W virtual channels using round-robin VC arbitration.
- Replaces the downstream per-VC bp wires with per-VC credit counters, so the link can be registered or pipelined without losing flits.
- Output is registered, giving one cycle of latency, and carries a one-hot VC valid.

Parameters:
- N, DEFAULT_N: number of clients; passed through for consistency, unused internally.
- A_W, DEFAULT_A_W: address width.
- D_W, DEFAULT_D_W: data width; payload is A_W+D_W+1 bits.
- VC_W, DEFAULT_VC_W: number of virtual channels.
- CREDITS, 4: downstream buffer depth per VC, equal to the credit counter reset value; must be ≥1.
- CNT_W, $clog2(CREDITS+1): credit counter width; derived, do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- i  in  [VC_W-1:0][A_W+D_W:0]  per-VC payload from the switch output side.
- i_v  in  VC_W  per-VC payload valid.
- i_bp  out  VC_W  per-VC backpressure to the switch. Combinational.
- o  out  A_W+D_W+1  link payload. Registered.
- o_v  out  VC_W  link valid, one-hot or zero. Registered.
- credit_ret  in  VC_W  downstream returns one credit on VC v when bit v is high for one cycle; multiple bits may be high in the same cycle.
- credit_avail  out  VC_W  bit v = (cnt[v] != 0), from registered counts.
- cred_ovf  out  1  sticky error: a credit was returned to a VC whose count was already full.

Behaviour:
- State:
  - cnt[v] (CNT_W bits) per VC.
  - Round-robin pointer ptr (clog2(VC_W) bits), pointing at the highest-priority VC.
  - Output registers o and o_v.
  - cred_ovf flag.
- Reset (sync, rst=1 at posedge):
  - cnt[v]=CREDITS, ptr=0, o='0, o_v='0, cred_ovf=0.
  - While rst is high, i_bp = i_v, so nothing is granted.
- Eligibility:
  - elig[v] = i_v[v] & (cnt[v] != 0), using the registered count only.
  - A credit returned in cycle N is usable in cycle N+1.
- Grant:
  - gnt is one-hot: the first eligible VC scanning ptr, ptr+1, … with wrap modulo VC_W.
  - gnt is zero when no VC is eligible.
  - The arbiter is work-conserving: a VC without credits is skipped.
- Backpressure:
  - i_bp[v] = i_v[v] & ~gnt[v].
  - A flit on VC v is consumed at the posedge ending any cycle where i_v[v]=1 and i_bp[v]=0.
  - The source holds i[v] stable while i_bp[v]=1.
- Output register:
  - When gnt != 0: o <= i[g], o_v <= gnt.
  - When gnt == 0: o_v <= 0 and o holds its previous value.
  - Latency: a flit granted in cycle N appears on o/o_v in cycle N+1.
- Pointer:
  - On grant of VC g: ptr <= (g+1) mod VC_W.
  - Unchanged when there is no grant.
- Credit update per VC each posedge: cnt[v] <= cnt[v] - gnt[v] + credit_ret[v], with these rules:
  - Grant and return on the same VC in the same cycle leaves the count unchanged. This is legal even at cnt=1.
  - A return with no grant when cnt==CREDITS: the count is held and cred_ovf <= 1.
  - cnt never underflows, because a grant requires cnt != 0.
  - cred_ovf is cleared only by rst.
- Reset mid-stream:
  - Any in-flight o_v is dropped in the next cycle.
  - Counts return to CREDITS. The downstream buffer is reset by the same rst, so credits stay consistent.
- No combinational path exists from credit_ret to i_bp or o.
- Target RTL size: ~150-250 lines.

Test Plan:
All scenarios use VC_W=2 and CREDITS=4.
1. Credit exhaustion on one VC:
   - Stimulus: i_v=2'b01, i[0]=36'h0_ABCDABCD held, no credit_ret.
   - Required: o_v=2'b01 with that payload for 4 consecutive cycles; then i_bp=2'b01, o_v=0, credit_avail=2'b10.
   - Pulse credit_ret=2'b01: exactly one more flit appears 2 cycles later.
2. Round-robin between VCs:
   - Stimulus: i_v=2'b11, credit_ret=o_v every cycle (loopback).
   - Required: o_v sequence 01,10,01,10,… starting with VC0 after reset; i_bp alternates 10,01.
3. Work conservation:
   - Stimulus: drain VC1 to cnt=0, then i_v=2'b11 with credit_ret=2'b01 every cycle.
   - Required: VC0 granted every cycle, i_bp=2'b10 constant, credit_avail[1]=0.
4. Simultaneous grant and return:
   - Stimulus: cnt[0]=1, i_v=2'b01, credit_ret=2'b01 in the same cycle.
   - Required: grant occurs, cnt[0] stays 1, and VC0 is granted again the next cycle with no bubble.
5. Overflow:
   - Stimulus: idle at reset, credit_ret=2'b10 for one cycle.
   - Required: cnt[1] stays 4, cred_ovf=1 from the next cycle and stays 1 until rst.
6. Reset mid-stream:
   - Stimulus: assert rst for one cycle during scenario 2.
   - Required: the next cycle shows o_v=0, cred_ovf=0, credit_avail=2'b11; the first grant after release is VC0.
